tsc_cache: RTL and testbench

//  Parametrised direct-mapped cache between the TSC CPU memory port (i_* or d_* side) and

---
 rtl/tsc_cache.sv | 157 +++++++++++++++
 tb/tb_tsc_cache.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tsc_cache.sv
// Direct-mapped, write-through, no-write-allocate cache for the TSC CPU memory port.
// Read hits complete in the same cycle; misses refill a whole line with one req/ack beat.
module tsc_cache #(
  parameter int WORD_SIZE      = 16,
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cpu_read,
  input  logic                                cpu_write,
  input  logic [WORD_SIZE-1:0]                cpu_addr,
  input  logic [WORD_SIZE-1:0]                cpu_wdata,
  output logic [WORD_SIZE-1:0]                cpu_rdata,
  output logic                                cpu_ready,
  input  logic                                flush,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [WORD_SIZE-1:0]                mem_addr,
  output logic [WORD_SIZE-1:0]                mem_wdata,
  input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                                mem_ack,
  output logic [WORD_SIZE-1:0]                hit_count,
  output logic [WORD_SIZE-1:0]                miss_count
);
  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int TAG_BITS = WORD_SIZE - IDX_BITS - OFF_BITS;
  localparam logic [WORD_SIZE-1:0] SAT = '1;
  localparam logic [WORD_SIZE-1:0] ONE = 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t               state_reg, state_next;
  logic [NUM_LINES-1:0] valid_reg;
  logic [TAG_BITS-1:0]  tag_reg   [NUM_LINES];
  logic [WORD_SIZE-1:0] words_reg [NUM_LINES][WORDS_PER_LINE];
  logic                 refilled_reg;
  logic [WORD_SIZE-1:0] hit_reg, miss_reg;
  logic [WORD_SIZE-1:0] mem_addr_reg, mem_wdata_reg;

  logic [TAG_BITS-1:0]  cpu_tag, fill_tag;
  logic [IDX_BITS-1:0]  cpu_idx, fill_idx;
  logic [OFF_BITS-1:0]  cpu_off;
  logic                 hit;
  logic [WORD_SIZE-1:0] fill_words [WORDS_PER_LINE];
  logic                 ready_int, rd_hit, rd_miss, start_write, fill_done, write_done, flush_now;

  assign cpu_tag  = cpu_addr[WORD_SIZE-1 -: TAG_BITS];
  assign cpu_idx  = cpu_addr[OFF_BITS +: IDX_BITS];
  assign cpu_off  = cpu_addr[OFF_BITS-1:0];
  // The refill target comes from the latched line address, not the live CPU bus.
  assign fill_tag = mem_addr_reg[WORD_SIZE-1 -: TAG_BITS];
  assign fill_idx = mem_addr_reg[OFF_BITS +: IDX_BITS];
  assign hit      = valid_reg[cpu_idx] && (tag_reg[cpu_idx] == cpu_tag);

  for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_unpack
    assign fill_words[gi] = mem_rdata[gi*WORD_SIZE +: WORD_SIZE];
  end

  always_comb begin
    state_next  = state_reg;
    ready_int   = 1'b0;
    rd_hit      = 1'b0;
    rd_miss     = 1'b0;
    start_write = 1'b0;
    fill_done   = 1'b0;
    write_done  = 1'b0;
    flush_now   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush) begin
          flush_now = 1'b1;
        end else if (cpu_write) begin
          start_write = 1'b1;
          state_next  = WRITE;
        end else if (cpu_read) begin
          if (hit) begin
            ready_int = 1'b1;
            rd_hit    = 1'b1;
          end else begin
            rd_miss    = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          fill_done  = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          write_done = 1'b1;
          ready_int  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_ready  = ready_int && !reset;
  assign cpu_rdata  = (rd_hit && !reset) ? words_reg[cpu_idx][cpu_off] : '0;
  assign mem_req    = (state_reg != IDLE) && !reset;
  assign mem_we     = (state_reg == WRITE) && !reset;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign hit_count  = hit_reg;
  assign miss_count = miss_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      valid_reg     <= '0;
      refilled_reg  <= 1'b0;
      hit_reg       <= '0;
      miss_reg      <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (flush_now)
        valid_reg <= '0;
      else if (fill_done)
        valid_reg[fill_idx] <= 1'b1;
      // The first hit after a refill is the replayed miss, so it is not counted again.
      if (fill_done)
        refilled_reg <= 1'b1;
      else if (ready_int)
        refilled_reg <= 1'b0;
      if (rd_hit && !refilled_reg && hit_reg != SAT)
        hit_reg <= hit_reg + ONE;
      if (rd_miss && miss_reg != SAT)
        miss_reg <= miss_reg + ONE;
      if (rd_miss) begin
        mem_addr_reg <= {cpu_tag, cpu_idx, {OFF_BITS{1'b0}}};
      end else if (start_write) begin
        mem_addr_reg  <= cpu_addr;
        mem_wdata_reg <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_done) begin
        tag_reg[fill_idx] <= fill_tag;
        for (int k = 0; k < WORDS_PER_LINE; k++)
          words_reg[fill_idx][k] <= fill_words[k];
      end else if (write_done && hit) begin
        words_reg[cpu_idx][cpu_off] <= mem_wdata_reg;
      end
    end
  end
endmodule

// File: tb/tb_tsc_cache.sv
// Bench for tsc_cache: directed scenarios plus a randomized mix, checked against a
// line-level model of the cache contents backed by a small word-addressed memory.
module tb_tsc_cache;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, cpu_read, cpu_write, flush, mem_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, hit_count, miss_count;
  logic        cpu_ready, mem_req, mem_we;
  logic [63:0] mem_rdata;

  logic        reset2, cpu_read2, cpu_write2, flush2, mem_ack2;
  logic [7:0]  cpu_addr2, cpu_wdata2, cpu_rdata2, mem_addr2, mem_wdata2, hit_count2, miss_count2;
  logic        cpu_ready2, mem_req2, mem_we2;
  logic [31:0] mem_rdata2;

  tsc_cache dut (
    .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  tsc_cache #(.WORD_SIZE(8)) dut_sat (
    .clk(clk), .reset(reset2), .cpu_read(cpu_read2), .cpu_write(cpu_write2),
    .cpu_addr(cpu_addr2), .cpu_wdata(cpu_wdata2), .cpu_rdata(cpu_rdata2), .cpu_ready(cpu_ready2),
    .flush(flush2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2),
    .hit_count(hit_count2), .miss_count(miss_count2)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: backing memory plus which line address each index holds.
  logic [15:0] bmem [256];
  logic [5:0]  line_of [4];
  bit          vld [4];
  int          m_hit, m_miss;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit m_is_hit(input logic [15:0] a);
    return vld[a[3:2]] && (line_of[a[3:2]] == a[7:2]);
  endfunction

  function automatic logic [63:0] line_data(input logic [15:0] a);
    logic [63:0] ld;
    logic [7:0]  base;
    base = {a[7:2], 2'b00};
    for (int k = 0; k < 4; k++) ld[k*16 +: 16] = bmem[base + 8'(k)];
    return ld;
  endfunction

  task automatic chk_counters();
    @(negedge clk);
    chk("hit_count", hit_count, 64'(m_hit));
    chk("miss_count", miss_count, 64'(m_miss));
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [15:0] a, input int lat, input bit flush_at_ack);
    bit h;
    h = m_is_hit(a);
    cpu_read = 1'b1;
    cpu_addr = a;
    @(negedge clk);
    chk("rd_ready", cpu_ready, h);
    if (h) begin
      chk("rd_hit_data", cpu_rdata, bmem[a[7:0]]);
      if (m_hit < 65535) m_hit++;
    end else begin
      chk("rd_miss_req_idle", mem_req, 1'b0);
      if (m_miss < 65535) m_miss++;
      @(posedge clk); #1;
      for (int i = 0; i <= lat; i++) begin
        mem_ack   = (i == lat);
        mem_rdata = line_data(a);
        flush     = flush_at_ack && (i == lat);
        @(negedge clk);
        chk("fill_req", mem_req, 1'b1);
        chk("fill_we", mem_we, 1'b0);
        chk("fill_addr", mem_addr, {a[15:2], 2'b00});
        chk("fill_ready", cpu_ready, 1'b0);
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      flush   = 1'b0;
      vld[a[3:2]]     = 1'b1;
      line_of[a[3:2]] = a[7:2];
      @(negedge clk);
      chk("refill_ready", cpu_ready, 1'b1);
      chk("refill_data", cpu_rdata, bmem[a[7:0]]);
    end
    @(posedge clk); #1;
    cpu_read = 1'b0;
    $display("read  addr=%h data=%h %s", a, bmem[a[7:0]], h ? "hit" : "miss");
    chk_counters();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int lat);
    cpu_write = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    @(negedge clk);
    chk("wr_ready_idle", cpu_ready, 1'b0);
    chk("wr_req_idle", mem_req, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i <= lat; i++) begin
      mem_ack = (i == lat);
      @(negedge clk);
      chk("wr_req", mem_req, 1'b1);
      chk("wr_we", mem_we, 1'b1);
      chk("wr_addr", mem_addr, a);
      chk("wr_wdata", mem_wdata, d);
      chk("wr_ready", cpu_ready, (i == lat));
      @(posedge clk); #1;
    end
    mem_ack   = 1'b0;
    cpu_write = 1'b0;
    bmem[a[7:0]] = d;
    $display("write addr=%h data=%h %s", a, d, m_is_hit(a) ? "hit" : "miss");
    chk_counters();
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    cpu_read = 1'b1;
    cpu_addr = 16'h0010;
    @(negedge clk);
    chk("flush_ready", cpu_ready, 1'b0);
    chk("flush_rdata", cpu_rdata, 16'h0000);
    chk("flush_req", mem_req, 1'b0);
    @(posedge clk); #1;
    flush    = 1'b0;
    cpu_read = 1'b0;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    $display("flush");
    chk_counters();
  endtask

  initial begin
    logic [15:0] a;
    int r;
    reset = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0; flush = 1'b0; mem_ack = 1'b1;
    cpu_addr = 16'h0012; cpu_wdata = 16'h0000; mem_rdata = '0;
    reset2 = 1'b1; cpu_read2 = 1'b0; cpu_write2 = 1'b0; flush2 = 1'b0; mem_ack2 = 1'b0;
    cpu_addr2 = 8'h00; cpu_wdata2 = 8'h00; mem_rdata2 = 32'hDDCCBBAA;
    for (int i = 0; i < 256; i++) bmem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) begin vld[i] = 1'b0; line_of[i] = '0; end
    m_hit = 0; m_miss = 0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", cpu_ready, 1'b0);
    chk("rst_rdata", cpu_rdata, 16'h0000);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_hit", hit_count, 16'h0000);
    chk("rst_miss", miss_count, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0; cpu_read = 1'b0; mem_ack = 1'b0;
    $display("reset released");
    chk_counters();

    // Cold miss, then a same-line hit
    bmem[16] = 16'h1111; bmem[17] = 16'h2222; bmem[18] = 16'h3333; bmem[19] = 16'h4444;
    do_read(16'h0012, 2, 1'b0);
    do_read(16'h0011, 0, 1'b0);
    // Conflict on index 0
    do_read(16'h0020, 1, 1'b0);
    do_read(16'h0010, 0, 1'b0);
    // Write hit then read, write miss then read
    do_write(16'h0012, 16'hBEEF, 1);
    do_read(16'h0012, 0, 1'b0);
    do_write(16'h0040, 16'h1234, 0);
    do_read(16'h0040, 2, 1'b0);
    // Flush, then a refill whose ack cycle also carries flush
    do_flush();
    do_read(16'h0010, 1, 1'b1);
    do_read(16'h0013, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      a = 16'($urandom_range(0, 63));
      if (r < 6)      do_read(a, int'($urandom_range(0, 3)), 1'b0);
      else if (r < 9) do_write(a, 16'($urandom), int'($urandom_range(0, 2)));
      else            do_flush();
    end

    // Reset one cycle before the ack would arrive
    cpu_read = 1'b1;
    cpu_addr = 16'h0080;
    @(negedge clk);
    chk("t5_ready", cpu_ready, m_is_hit(16'h0080));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_fill_req", mem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_req_in_reset", mem_req, 1'b0);
    chk("t5_ready_in_reset", cpu_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; cpu_read = 1'b0; mem_ack = 1'b1;
    mem_rdata = line_data(16'h0080);
    @(negedge clk);
    chk("t5_req_after", mem_req, 1'b0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    m_hit = 0; m_miss = 0;
    $display("reset during fill");
    chk_counters();
    do_read(16'h0080, 0, 1'b0);

    // Saturation on an 8-bit instance
    reset2 = 1'b0;
    @(posedge clk); #1;
    cpu_read2 = 1'b1;
    cpu_addr2 = 8'h01;
    @(negedge clk);
    chk("sat_first_ready", cpu_ready2, 1'b0);
    @(posedge clk); #1;
    mem_ack2 = 1'b1;
    @(posedge clk); #1;
    mem_ack2 = 1'b0;
    @(negedge clk);
    chk("sat_refill_data", cpu_rdata2, 8'hBB);
    for (int j = 1; j <= 260; j++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("sat_hit_count", hit_count2, 64'((j - 1 > 255) ? 255 : j - 1));
    end
    chk("sat_ready", cpu_ready2, 1'b1);
    chk("sat_miss_count", miss_count2, 8'h01);
    @(posedge clk); #1;
    cpu_read2 = 1'b0;
    $display("saturation run hit_count=%0d", hit_count2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
